// File: rtl/busca_instrucao_if.sv
// busca_instrucao_if: memory read bus plus the decode-side valid/stall
// handshake of the instruction-fetch stage. The fetch stage uses the master
// modport; instruction memory and decode sit behind the slave modport.
interface busca_instrucao_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_dado;
    logic        id_stall;
    logic        id_valido;
    logic [31:0] id_instrucao;
    logic [31:0] id_pc;
    logic [31:0] id_pc_mais4;

    modport master (
        output mem_req, mem_addr, id_valido, id_instrucao, id_pc, id_pc_mais4,
        input  mem_ack, mem_dado, id_stall
    );

    modport slave (
        input  mem_req, mem_addr, id_valido, id_instrucao, id_pc, id_pc_mais4,
        output mem_ack, mem_dado, id_stall
    );
endinterface

// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction-fetch stage. Keeps the fetch PC, keeps at most
// one read outstanding to instruction memory, buffers returned words with
// their PC in a 2-entry prefetch queue and hands the head to decode.
// Redirects flush the queue and drop the data of a request already in flight.
// Optional feature macro: BUSCA_CONTADOR_EN adds the contador_busca output,
// a count of instructions accepted by decode.
module busca_instrucao #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    busca_instrucao_if.master bus,
    input  logic        desvio,
    input  logic [31:0] alvo
`ifdef BUSCA_CONTADOR_EN
    ,
    output logic [31:0] contador_busca
`endif
);

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] BUSCA    = 2'd1;
    localparam logic [1:0] DESCARTA = 2'd2;

    logic [1:0]  estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [1:0]  ocup_q, ocup_d;
    logic [31:0] inst0_q, inst0_d;
    logic [31:0] pc0_q, pc0_d;
    logic [31:0] inst1_q, inst1_d;
    logic [31:0] pc1_q, pc1_d;

    logic        push;
    logic        pop;
    logic        livre;
    logic [31:0] alvo_alinhado;
    logic [31:0] pc_apos;
    logic [1:0]  ocup_apos;

    // Next-state: redirect wins over everything, otherwise pop/push the queue
    // and issue a new read whenever the memory port is free and there will be room.
    always_comb begin
        alvo_alinhado = alvo & 32'hFFFF_FFFC;
        pop           = (ocup_q != 2'd0) && !bus.id_stall;
        push          = (estado_q == BUSCA) && bus.mem_ack;
        livre         = (estado_q == OCIOSO) || push;
        pc_apos       = push ? pc_q + 32'd4 : pc_q;
        ocup_apos     = ocup_q + {1'b0, push} - {1'b0, pop};

        estado_d   = estado_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ocup_d     = ocup_q;
        inst0_d    = inst0_q;
        pc0_d      = pc0_q;
        inst1_d    = inst1_q;
        pc1_d      = pc1_q;

        if (desvio) begin
            ocup_d = 2'd0;
            pc_d   = alvo_alinhado;
            case (estado_q)
                OCIOSO: begin
                    estado_d   = BUSCA;
                    mem_req_d  = 1'b1;
                    mem_addr_d = alvo_alinhado;
                end
                BUSCA: begin
                    if (bus.mem_ack) begin
                        estado_d  = OCIOSO;
                        mem_req_d = 1'b0;
                    end else begin
                        estado_d  = DESCARTA;
                    end
                end
                default: begin
                    if (bus.mem_ack) begin
                        estado_d  = OCIOSO;
                        mem_req_d = 1'b0;
                    end
                end
            endcase
        end else begin
            pc_d   = pc_apos;
            ocup_d = ocup_apos;

            if (pop) begin
                inst0_d = inst1_q;
                pc0_d   = pc1_q;
            end
            if (push) begin
                if (ocup_apos == 2'd1) begin
                    inst0_d = bus.mem_dado;
                    pc0_d   = mem_addr_q;
                end else begin
                    inst1_d = bus.mem_dado;
                    pc1_d   = mem_addr_q;
                end
            end

            if (estado_q == DESCARTA) begin
                if (bus.mem_ack) begin
                    estado_d  = OCIOSO;
                    mem_req_d = 1'b0;
                end
            end else if (livre) begin
                if (ocup_apos < 2'd2) begin
                    estado_d   = BUSCA;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_apos;
                end else begin
                    estado_d  = OCIOSO;
                    mem_req_d = 1'b0;
                end
            end
        end
    end

    // State, request and queue registers; reset abandons any in-flight read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            ocup_q     <= 2'd0;
            inst0_q    <= 32'd0;
            pc0_q      <= 32'd0;
            inst1_q    <= 32'd0;
            pc1_q      <= 32'd0;
        end else begin
            estado_q   <= estado_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ocup_q     <= ocup_d;
            inst0_q    <= inst0_d;
            pc0_q      <= pc0_d;
            inst1_q    <= inst1_d;
            pc1_q      <= pc1_d;
        end
    end

    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.id_valido    = (ocup_q != 2'd0);
    assign bus.id_instrucao = inst0_q;
    assign bus.id_pc        = pc0_q;
    assign bus.id_pc_mais4  = pc0_q + 32'd4;

`ifdef BUSCA_CONTADOR_EN
    logic [31:0] contador_q;

    // Count only real handoffs to decode; a redirect edge flushes instead of popping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador_q <= 32'd0;
        end else if (pop && !desvio) begin
            contador_q <= contador_q + 32'd1;
        end
    end

    assign contador_busca = contador_q;
`endif

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction-fetch stage of the processor, directly upstream of the decode stage. Holds the fetch PC, issues one-outstanding-request reads to instruction memory, buffers returned words with their PC in a 2-entry prefetch queue, and presents them to decode with a valid/stall handshake. Also produces PC+4 for the result multiplexer's PC input. Handles branch redirects, discarding stale memory responses.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset (byte address, word aligned)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mem_req  out  1  read request to instruction memory (registered)
- mem_addr  out  32  word-aligned read address; stable while mem_req=1
- mem_ack  in  1  read completes this cycle; mem_dado valid
- mem_dado  in  32  instruction word
- desvio  in  1  redirect pulse (branch/jump taken)
- alvo  in  32  redirect target; bits [1:0] ignored (forced 0)
- id_stall  in  1  decode cannot accept this cycle
- id_valido  out  1  id_instrucao/id_pc valid
- id_instrucao  out  32  queue head instruction ([27:24] Sel_C_A, [23:20] Sel_B, [15:0] constante fields go to decode)
- id_pc  out  32  address of id_instrucao
- id_pc_mais4  out  32  id_pc + 4 (link value to result mux)
- contador_busca  out  32  instructions accepted by decode (only with BUSCA_CONTADOR_EN)

## Operation
- States: OCIOSO (no request), BUSCA (request outstanding), DESCARTA (outstanding request whose data is dropped).
- Reset: state OCIOSO, pc_busca=RESET_PC, mem_req=0, mem_addr=0, queue empty, id_valido=0, id_instrucao=0, id_pc=0, id_pc_mais4=4, contador_busca=0.
- Issue rule: at an edge with no outstanding request (or the outstanding one completing), issue a new request iff occupancy_after_edge < 2; mem_req=1, mem_addr=pc_busca, state BUSCA.
- Completion: mem_req&mem_ack at an edge in BUSCA → push {mem_dado, mem_addr} to queue tail, pc_busca += 4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
- Pop: id_valido & !id_stall at an edge → head removed. Push and pop in the same edge allowed at any occupancy (full queue: pop frees slot, push fills it).
- Decode outputs come straight from queue head registers; id_valido = occupancy≠0. No combinational path from id_stall or mem_* to any output.
- Redirect (desvio=1 at an edge): highest priority. Queue flushed (no pop counted), pc_busca={alvo[31:2],2'b00}. If a request is outstanding and mem_ack=0 → DESCARTA, mem_req stays 1 with old address until ack, then that data is dropped and the next edge issues at alvo. If mem_ack=1 same cycle → data dropped, state OCIOSO, new request at alvo issued the next edge. With no outstanding request → request to alvo issued at that same edge.
- desvio during DESCARTA: only pc_busca updated; still one stale ack to drop.
- Reset mid-operation: immediate return to reset values; memory must drop any in-flight request on reset.

## Timing
- Request-to-memory: mem_req rises on first edge after reset deassertion.
- Ack-to-decode latency: instruction visible (id_valido=1) in the cycle after the edge at which mem_ack sampled high.
- Zero-wait memory (ack in same cycle as req), no stall: one instruction per cycle sustained, mem_req continuously high.
- Redirect penalty with zero-wait memory: alvo instruction valid 2 cycles after the desvio edge.
- Max outstanding requests: 1; queue occupancy + outstanding ≤ 2 always.

## Configuration
- BUSCA_CONTADOR_EN defined: contador_busca port present, incremented by 1 on every pop (wraps at 2^32), cleared by reset; flushed entries not counted.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset release, zero-wait memory returning addr^32'hA5A5_0000, id_stall=0 → mem_addr 0,4,8,…; id_valido from cycle 2, id_pc 0,4,8 on consecutive cycles, id_pc_mais4 = id_pc+4.
- id_stall=1 for 5 cycles → queue fills at 2 entries, mem_req drops; release → heads 0,4,8 in order, none lost or duplicated.
- Memory 3-cycle latency, desvio with alvo=0x103 while request at 0x8 outstanding → 0x8 data dropped, next mem_addr=0x100, id_pc=0x100 first valid.
- RESET_PC=32'hFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- desvio coincident with mem_ack and full queue → queue empty next cycle, no push, next request at alvo.
- BUSCA_CONTADOR_EN: 10 pops, 2 flushed entries → contador_busca=10; reset asserted mid-burst → all outputs at reset values asynchronously.
